majority_vote_filter: RTL and testbench
=======================================

# majority_vote_filter

Parametrised, pipelined M-of-N majority voter with temporal persistence filtering, used to vote redundant channel bits (sensor/TMR replicas) into a single glitch-free decision. Each valid sample is popcounted and compared against a threshold. The voted result only changes after the new decision has persisted for a programmable number of valid samples. It extends our fixed 5-input combinational majority circuit into a configurable, clocked block.

## Interface
Parameters:
- `N`, default 5: number of input channels, 1..32.
- `THRESH`, default N/2+1: minimum count of ones for a raw vote of 1, in 1..N. Elaboration error if outside this range.
- `HOLD`, default 1: consecutive disagreeing valid samples required to flip `z`, in 1..255.

Ports (reset is synchronous and active-high):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `x` holds a sample this cycle.
- `x`, in, N: channel bits; `x[i]` is channel i.
- `clr_disagree`, in, 1: pulse that clears sticky disagree flags.
- `count`, out, CW = $clog2(N+1): popcount of the last valid sample.
- `z`, out, 1: filtered vote.
- `z_valid`, out, 1: one-cycle pulse, two cycles after each accepted sample.
- `disagree`, out, N: sticky per-channel miscompare flags.

## Operation
- Stage 1, registered on `in_valid`: `cnt_q` = popcount(`x`); `raw_q` = (`cnt_q` >= `THRESH`); `x_q` = `x`; `v1_q` = `in_valid`. `count` is driven by `cnt_q` and holds between samples.
- Stage 2: a filter FSM runs on `v1_q` with states IDLE, TRACK and PEND, plus `hold_cnt` (8 bit).
  - IDLE: on `v1_q`, `z` <= `raw_q`, go to TRACK. The first sample after reset loads directly with no hold.
  - TRACK: on `v1_q` with `raw_q` != `z`: if HOLD == 1, flip `z` and stay in TRACK; otherwise `hold_cnt` <= 1 and go to PEND.
  - PEND: on `v1_q` with `raw_q` == `z`: clear `hold_cnt`, go to TRACK. On `v1_q` with `raw_q` != `z`: increment `hold_cnt`; when the incremented value equals HOLD, flip `z`, clear `hold_cnt`, go to TRACK.
  - Cycles with `v1_q` = 0 neither advance nor clear `hold_cnt`; the FSM holds its state.
- `z_valid` <= `v1_q` every cycle. It pulses once per accepted sample, including samples that do not change `z`.
- Back-to-back samples are accepted every cycle with no stall and no backpressure.
- `rst` (synchronous) clears all of the following:
  - pipeline registers and `v1_q`;
  - `count` = 0, `z` = 0, `z_valid` = 0, `disagree` = 0;
  - FSM to IDLE, `hold_cnt` = 0.
- `rst` mid-operation flushes any in-flight sample; no `z_valid` pulse is produced for it.

## Timing
- Sample on `in_valid` at edge k:
  - `count` updates at edge k+1;
  - `z` and `z_valid` update at edge k+2.
- Latency is fixed at 2 cycles; throughput is 1 sample per cycle.
- Worst-case `z` flip: 2 + (HOLD − 1) cycles after the first disagreeing sample, when samples are contiguous.
- Simultaneous `clr_disagree` and a new miscompare on bit i: the set wins, so bit i = 1.

## Configuration
- `MAJ_DISAGREE_EN` defined:
  - stage 2 sets `disagree[i]` whenever `v1_q` = 1 and `x_q[i]` != `raw_q`;
  - flags are sticky until `clr_disagree` or `rst`.
- `MAJ_DISAGREE_EN` undefined:
  - no flag registers are built;
  - `disagree` is tied to 0 and `clr_disagree` is ignored;
  - ports remain present so the bench is unchanged.

## Structure
- Package `maj_pkg`:
  - FSM state enum (IDLE, TRACK, PEND);
  - function `maj_cw(n)` returning $clog2(n+1);
  - `HOLD_W` = 8.
- Sub-module `maj_popcount`: combinational, parameter N, input `x[N-1:0]`, output `cnt[CW-1:0]`, built as an adder tree.
- Top level contains the stage 1 registers, the filter FSM and the optional disagree flags.

## Test plan
All scenarios use N=5, THRESH=3 unless noted.
- Reset, then `x`=00111 valid for one cycle: `count`=3 at +1; `z`=1 with a single `z_valid` pulse at +2 (IDLE load).
- HOLD=1, sweep `x`=0..31 back-to-back: at each +2, `z` = (popcount ≥ 3), `count` matches popcount, and `z_valid` is high for 32 consecutive cycles.
- HOLD=3, `z`=1:
  - samples 00001, 00001, 11111, then 00001 ×3;
  - `z` stays 1 through the first three samples (counter cleared by 11111);
  - `z` falls to 0 two cycles after the third 00001.
- HOLD=3, samples 00000, [gap of 4 idle cycles], 00000, [gap], 00000 while `z`=1: `z` falls after the third sample; gaps do not reset `hold_cnt`.
- HOLD=3, `rst` asserted while in PEND with `hold_cnt`=2:
  - next cycle `z`=0, `z_valid`=0, `count`=0;
  - next sample 11100 loads `z`=1 directly.
- With `MAJ_DISAGREE_EN`:
  - `x`=11110 gives `disagree`=00001;
  - `clr_disagree` pulsed together with a new miscompare on bit 0 leaves bit 0 = 1;
  - a lone `clr_disagree` clears it to 0.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared types and helpers for the majority vote filter: FSM encoding, count width, hold counter width.
package maj_pkg;

   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      PEND  = 2'd2
   } maj_state_e;

   function automatic int maj_cw(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/maj_popcount.sv
// Combinational popcount of N channel bits as a balanced adder tree; zero latency, no flow control.
module maj_popcount
   import maj_pkg::*;
#(
   parameter int  N  = 5,
   localparam int CW = maj_cw(N)
) (
   input  logic [N-1:0]  x,
   output logic [CW-1:0] cnt
);

   // Leaves padded to a power of two so every tree level halves cleanly.
   localparam int P = 1 << $clog2(N);

   logic [P-1:0]  xp;
   logic [CW-1:0] lvl [P];

   always_comb begin
      xp = P'(x);
      for (int i = 0; i < P; i++) begin
         lvl[i] = CW'(xp[i]);
      end
      for (int w = P / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            lvl[i] = lvl[2 * i] + lvl[2 * i + 1];
         end
      end
      cnt = lvl[0];
   end

endmodule

// File: rtl/majority_vote_filter.sv
// M-of-N voter with HOLD-sample persistence filter; 2-cycle latency, 1 sample/cycle, no backpressure.
// Sticky per-channel miscompare flags are built only when MAJ_DISAGREE_EN is defined.
module majority_vote_filter
   import maj_pkg::*;
#(
   parameter int  N      = 5,
   parameter int  THRESH = N / 2 + 1,
   parameter int  HOLD   = 1,
   localparam int CW     = maj_cw(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [N-1:0]  x,
   input  logic          clr_disagree,
   output logic [CW-1:0] count,
   output logic          z,
   output logic          z_valid,
   output logic [N-1:0]  disagree
);

   if (N < 1 || N > 32) begin : g_bad_n
      $error("majority_vote_filter: N must be in 1..32");
   end
   if (THRESH < 1 || THRESH > N) begin : g_bad_thresh
      $error("majority_vote_filter: THRESH must be in 1..N");
   end
   if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
      $error("majority_vote_filter: HOLD must be in 1..255");
   end

   localparam logic [CW-1:0]     THRESH_C = CW'(THRESH);
   localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(HOLD);

   logic [CW-1:0] pop;
   logic [CW-1:0] cnt_q;
   logic          raw_q;
   logic          v1_q;

   maj_popcount #(.N(N)) u_pop (
      .x   (x),
      .cnt (pop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         raw_q <= 1'b0;
         v1_q  <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            cnt_q <= pop;
            raw_q <= (pop >= THRESH_C);
         end
      end
   end

   maj_state_e        state_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic              z_q;
   logic              z_valid_q;

   // Non-valid cycles leave state and hold_cnt untouched, so gaps never reset persistence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         z_q        <= 1'b0;
         z_valid_q  <= 1'b0;
      end else begin
         z_valid_q <= v1_q;
         if (v1_q) begin
            case (state_q)
               IDLE: begin
                  z_q     <= raw_q;
                  state_q <= TRACK;
               end
               TRACK: begin
                  if (raw_q != z_q) begin
                     if (HOLD == 1) begin
                        z_q <= raw_q;
                     end else begin
                        hold_cnt_q <= HOLD_W'(1);
                        state_q    <= PEND;
                     end
                  end
               end
               PEND: begin
                  if (raw_q == z_q) begin
                     hold_cnt_q <= '0;
                     state_q    <= TRACK;
                  end else if (hold_cnt_q + HOLD_W'(1) == HOLD_C) begin
                     z_q        <= raw_q;
                     hold_cnt_q <= '0;
                     state_q    <= TRACK;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign count   = cnt_q;
   assign z       = z_q;
   assign z_valid = z_valid_q;

`ifdef MAJ_DISAGREE_EN
   logic [N-1:0] x_q;
   logic [N-1:0] disagree_q;
   logic [N-1:0] disagree_d;

   // A miscompare in the same cycle as a clear takes priority over the clear.
   always_comb begin
      disagree_d = clr_disagree ? '0 : disagree_q;
      if (v1_q) begin
         disagree_d = disagree_d | (x_q ^ {N{raw_q}});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         disagree_q <= '0;
      end else begin
         if (in_valid) begin
            x_q <= x;
         end
         disagree_q <= disagree_d;
      end
   end

   assign disagree = disagree_q;
`else
   logic unused_clr;
   assign unused_clr = clr_disagree;
   assign disagree   = '0;
`endif

endmodule

// File: tb/tb_majority_vote_filter.sv
// Directed bench: two filters (HOLD=1, HOLD=3) share stimulus; each task checks its own scenario.
module tb_majority_vote_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [4:0] x;
   logic       clr;

   logic [2:0] cnt1, cnt3;
   logic       z1, z3, zv1, zv3;
   logic [4:0] dis1, dis3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   majority_vote_filter #(.N(5), .THRESH(3), .HOLD(1)) u_h1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr_disagree(clr),
      .count(cnt1), .z(z1), .z_valid(zv1), .disagree(dis1)
   );

   majority_vote_filter #(.N(5), .THRESH(3), .HOLD(3)) u_h3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr_disagree(clr),
      .count(cnt3), .z(z3), .z_valid(zv3), .disagree(dis3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      x        = '0;
      clr      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_ones();
      in_valid = 1'b1;
      x        = 5'b11111;
      tick();
      idle();
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt1); end
      checks++; if (z1 !== 1'b0) begin errors++; $display("FAIL reset_z1 got %b exp 0", z1); end
      checks++; if (zv3 !== 1'b0) begin errors++; $display("FAIL reset_zv3 got %b exp 0", zv3); end
      checks++; if (dis3 !== 5'd0) begin errors++; $display("FAIL reset_dis got %b exp 00000", dis3); end
   endtask

   task automatic test_single_sample();
      in_valid = 1'b1;
      x        = 5'b00111;
      tick();
      idle();
      checks++; if (cnt1 !== 3'd3) begin errors++; $display("FAIL single_count got %0d exp 3", cnt1); end
      checks++; if (zv1 !== 1'b0) begin errors++; $display("FAIL single_zv_early got %b exp 0", zv1); end
      tick();
      checks++; if (z1 !== 1'b1) begin errors++; $display("FAIL single_z1 got %b exp 1", z1); end
      checks++; if (zv1 !== 1'b1) begin errors++; $display("FAIL single_zv1 got %b exp 1", zv1); end
      checks++; if (z3 !== 1'b1) begin errors++; $display("FAIL single_z3_idle_load got %b exp 1", z3); end
      tick();
      checks++; if (zv1 !== 1'b0) begin errors++; $display("FAIL single_zv_pulse got %b exp 0", zv1); end
      checks++; if (cnt1 !== 3'd3) begin errors++; $display("FAIL single_count_hold got %0d exp 3", cnt1); end
   endtask

   task automatic test_sweep();
      int hits = 0;
      for (int j = 0; j <= 32; j++) begin
         logic [4:0] xs;
         logic [4:0] xp;
         logic       zexp;
         if (j < 32) begin
            in_valid = 1'b1;
            x        = 5'(j);
         end else begin
            idle();
         end
         tick();
         if (j < 32) begin
            xs = 5'(j);
            checks++;
            if (cnt1 !== 3'($countones(xs))) begin
               errors++; $display("FAIL sweep_count x=%0d got %0d exp %0d", j, cnt1, $countones(xs));
            end
         end
         if (j >= 1) begin
            xp   = 5'(j - 1);
            zexp = ($countones(xp) >= 3);
            checks++;
            if (z1 !== zexp) begin
               errors++; $display("FAIL sweep_z x=%0d got %b exp %b", j - 1, z1, zexp);
            end
            if (zv1 === 1'b1) hits++;
         end
      end
      checks++; if (hits != 32) begin errors++; $display("FAIL sweep_zv_count got %0d exp 32", hits); end
      tick();
      checks++; if (zv1 !== 1'b0) begin errors++; $display("FAIL sweep_zv_end got %b exp 0", zv1); end
   endtask

   task automatic test_hold_persist();
      logic [4:0] smp  [6] = '{5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00001, 5'b00001};
      logic       exp3 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      load_ones();
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            in_valid = 1'b1;
            x        = smp[i];
         end else begin
            idle();
         end
         tick();
         if (i >= 1) begin
            checks++;
            if (z3 !== exp3[i - 1]) begin
               errors++; $display("FAIL hold3_z sample=%0d got %b exp %b", i - 1, z3, exp3[i - 1]);
            end
            checks++;
            if (z1 !== exp1[i - 1]) begin
               errors++; $display("FAIL hold1_z sample=%0d got %b exp %b", i - 1, z1, exp1[i - 1]);
            end
         end
      end
      checks++; if (zv3 !== 1'b1) begin errors++; $display("FAIL hold3_zv_flip got %b exp 1", zv3); end
      idle();
      tick();
   endtask

   task automatic test_gap_persist();
      logic zexp;
      do_reset();
      load_ones();
      for (int s = 0; s < 3; s++) begin
         in_valid = 1'b1;
         x        = 5'b00000;
         tick();
         idle();
         tick();
         checks++; if (zv3 !== 1'b1) begin errors++; $display("FAIL gap_zv s=%0d got %b exp 1", s, zv3); end
         zexp = (s == 2) ? 1'b0 : 1'b1;
         checks++; if (z3 !== zexp) begin errors++; $display("FAIL gap_z s=%0d got %b exp %b", s, z3, zexp); end
         tick();
         checks++; if (zv3 !== 1'b0) begin errors++; $display("FAIL gap_zv_idle s=%0d got %b exp 0", s, zv3); end
         tick();
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_ones();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x        = 5'b00000;
         tick();
      end
      checks++; if (z3 !== 1'b1) begin errors++; $display("FAIL rmid_pend_z got %b exp 1", z3); end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (z3 !== 1'b0) begin errors++; $display("FAIL rmid_z got %b exp 0", z3); end
      checks++; if (zv3 !== 1'b0) begin errors++; $display("FAIL rmid_zv got %b exp 0", zv3); end
      checks++; if (cnt3 !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", cnt3); end
      tick();
      checks++; if (zv3 !== 1'b0) begin errors++; $display("FAIL rmid_flush_zv got %b exp 0", zv3); end
      in_valid = 1'b1;
      x        = 5'b11100;
      tick();
      idle();
      checks++; if (cnt3 !== 3'd3) begin errors++; $display("FAIL rmid_reload_count got %0d exp 3", cnt3); end
      tick();
      checks++; if (z3 !== 1'b1) begin errors++; $display("FAIL rmid_reload_z got %b exp 1", z3); end
      checks++; if (zv3 !== 1'b1) begin errors++; $display("FAIL rmid_reload_zv got %b exp 1", zv3); end
   endtask

   task automatic test_disagree();
      do_reset();
      in_valid = 1'b1;
      x        = 5'b11110;
      tick();
      idle();
      tick();
`ifdef MAJ_DISAGREE_EN
      checks++; if (dis3 !== 5'b00001) begin errors++; $display("FAIL dis_set got %b exp 00001", dis3); end
      in_valid = 1'b1;
      x        = 5'b11110;
      tick();
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (dis3 !== 5'b00001) begin errors++; $display("FAIL dis_set_wins got %b exp 00001", dis3); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (dis3 !== 5'b00000) begin errors++; $display("FAIL dis_clear got %b exp 00000", dis3); end
      in_valid = 1'b1;
      x        = 5'b00011;
      tick();
      idle();
      tick();
      checks++; if (dis1 !== 5'b00011) begin errors++; $display("FAIL dis_low_vote got %b exp 00011", dis1); end
`else
      checks++; if (dis3 !== 5'b00000) begin errors++; $display("FAIL dis_off3 got %b exp 00000", dis3); end
      checks++; if (dis1 !== 5'b00000) begin errors++; $display("FAIL dis_off1 got %b exp 00000", dis1); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_single_sample();
      test_sweep();
      test_hold_persist();
      test_gap_persist();
      test_reset_mid();
      test_disagree();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
